layer_compositor_m: RTL and testbench



---
 rtl/layer_compositor_m.sv | 154 +++++++++++++++
 tb/tb_layer_compositor_m.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor_m.sv
// layer_compositor_m: per-pixel priority compositor for the video path.
// Picks the lowest-numbered opaque, enabled layer, or the backdrop colour
// when none qualifies, and blanks outside active video. Control registers
// (layer mask, backdrop, optional colour key) are written into a pending
// set and copied to the active set on vsync start, so a frame never tears.
// Sync signals travel through the same delay line as the colour.
//
// Optional feature: define COMPOSITOR_COLOR_KEY_EN to build the colour key
// (address CTRL_BASE+2). Without it that address is ignored.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous active-high reset
//   layer_rgb    LAYERS packed pixels, layer i at [i*3*CBITS +: 3*CBITS]
//   layer_valid  per-layer opaque flag
//   visible      active video for this pixel
//   hsync_in     horizontal sync, active-low
//   vsync_in     vertical sync, active-low
//   wr_en        control register write strobe
//   address      control register write address
//   data         control register write data
//   r, g, b      composited colour, LATENCY cycles after input
//   hsync, vsync syncs delayed by LATENCY
module layer_compositor_m #(
  parameter int unsigned LAYERS          = 2,
  parameter int unsigned CBITS           = 2,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned CTRL_BASE       = 0,
  parameter int unsigned VRAM_ADDR_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LAYERS*3*CBITS-1:0]    layer_rgb,
  input  logic [LAYERS-1:0]            layer_valid,
  input  logic                         visible,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic                         wr_en,
  input  logic [VRAM_ADDR_WIDTH-1:0]   address,
  input  logic [7:0]                   data,
  output logic [CBITS-1:0]             r,
  output logic [CBITS-1:0]             g,
  output logic [CBITS-1:0]             b,
  output logic                         hsync,
  output logic                         vsync
);

  localparam int unsigned PW     = 3 * CBITS;
  localparam int unsigned SW     = PW + 2;
  localparam int unsigned PIPE_W = LATENCY * SW;

  localparam logic [VRAM_ADDR_WIDTH-1:0] ADDR_MASK = VRAM_ADDR_WIDTH'(CTRL_BASE);
  localparam logic [VRAM_ADDR_WIDTH-1:0] ADDR_BACK = VRAM_ADDR_WIDTH'(CTRL_BASE + 1);
`ifdef COMPOSITOR_COLOR_KEY_EN
  localparam logic [VRAM_ADDR_WIDTH-1:0] ADDR_KEY  = VRAM_ADDR_WIDTH'(CTRL_BASE + 2);
`endif

  // One pipeline stage: {rgb, hsync, vsync}; reset is black with syncs idle.
  localparam logic [SW-1:0] STAGE_RST = {PW'(0), 2'b11};

  logic [LAYERS-1:0] mask_p_q, mask_p_d, mask_a_q, mask_a_d;
  logic [PW-1:0]     back_p_q, back_p_d, back_a_q, back_a_d;
`ifdef COMPOSITOR_COLOR_KEY_EN
  logic [PW-1:0]     key_p_q, key_p_d, key_a_q, key_a_d;
`endif
  logic              vs_prev_q;
  logic              vs_start;
  logic [LAYERS-1:0] eff;
  logic [PW-1:0]     sel_rgb;
  logic [PIPE_W-1:0] stage_q, stage_d;
  logic [SW-1:0]     out_stage;

  // Data bits above the widest register field carry no meaning.
  logic unused_data;
  assign unused_data = ^data;

  assign vs_start = ~vsync_in & vs_prev_q;

  // Pending writes and frame-boundary copy. The active "_d" values are also
  // what the select logic uses, so the vsync-start pixel sees the new set.
  always_comb begin : ctrl_next
    mask_p_d = mask_p_q;
    back_p_d = back_p_q;
`ifdef COMPOSITOR_COLOR_KEY_EN
    key_p_d  = key_p_q;
`endif
    if (wr_en) begin
      if (address == ADDR_MASK) mask_p_d = data[LAYERS-1:0];
      if (address == ADDR_BACK) back_p_d = data[PW-1:0];
`ifdef COMPOSITOR_COLOR_KEY_EN
      if (address == ADDR_KEY)  key_p_d  = data[PW-1:0];
`endif
    end
    mask_a_d = vs_start ? mask_p_q : mask_a_q;
    back_a_d = vs_start ? back_p_q : back_a_q;
`ifdef COMPOSITOR_COLOR_KEY_EN
    key_a_d  = vs_start ? key_p_q  : key_a_q;
`endif
  end

  // Priority select: scan from the lowest priority up so layer 0 wins last.
  always_comb begin : pixel_select
    eff = '0;
    for (int i = 0; i < int'(LAYERS); i++) begin
`ifdef COMPOSITOR_COLOR_KEY_EN
      eff[i] = layer_valid[i] & mask_a_d[i] & (layer_rgb[i*PW +: PW] != key_a_d);
`else
      eff[i] = layer_valid[i] & mask_a_d[i];
`endif
    end
    sel_rgb = back_a_d;
    for (int i = int'(LAYERS) - 1; i >= 0; i--) begin
      if (eff[i]) sel_rgb = layer_rgb[i*PW +: PW];
    end
    if (!visible) sel_rgb = '0;
  end

  // Delay line: stage 1 in the low slice, output stage in the high slice.
  assign stage_d = PIPE_W'({stage_q, sel_rgb, hsync_in, vsync_in});

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      mask_p_q  <= '1;
      mask_a_q  <= '1;
      back_p_q  <= '0;
      back_a_q  <= '0;
`ifdef COMPOSITOR_COLOR_KEY_EN
      key_p_q   <= '1;
      key_a_q   <= '1;
`endif
      vs_prev_q <= 1'b1;
      stage_q   <= {LATENCY{STAGE_RST}};
    end else begin
      mask_p_q  <= mask_p_d;
      mask_a_q  <= mask_a_d;
      back_p_q  <= back_p_d;
      back_a_q  <= back_a_d;
`ifdef COMPOSITOR_COLOR_KEY_EN
      key_p_q   <= key_p_d;
      key_a_q   <= key_a_d;
`endif
      vs_prev_q <= vsync_in;
      stage_q   <= stage_d;
    end
  end

  assign out_stage = stage_q[PIPE_W-1 -: SW];
  assign r     = out_stage[2+2*CBITS +: CBITS];
  assign g     = out_stage[2+CBITS +: CBITS];
  assign b     = out_stage[2 +: CBITS];
  assign hsync = out_stage[1];
  assign vsync = out_stage[0];

endmodule

// File: tb/tb_layer_compositor_m.sv
// tb_layer_compositor_m: self-checking bench for layer_compositor_m with
// LAYERS=3, CBITS=2, LATENCY=3 and a non-zero control base address.
// A behavioural model predicts {rgb, hsync, vsync} for every driven cycle
// and queues it; the entry is popped when the pipeline delivers it.
module tb_layer_compositor_m;

  localparam int          LAT  = 3;
  localparam logic [15:0] BASE = 16'h0040;

  logic        clk;
  logic        rst;
  logic [17:0] layer_rgb;
  logic [2:0]  layer_valid;
  logic        visible, hsync_in, vsync_in, wr_en;
  logic [15:0] address;
  logic [7:0]  data;
  logic [1:0]  r, g, b;
  logic        hsync, vsync;

  int checks;
  int errors;

  logic [7:0] sb[$];

  // Model state
  logic [2:0] m_mask_p, m_mask_a;
  logic [5:0] m_back_p, m_back_a;
`ifdef COMPOSITOR_COLOR_KEY_EN
  logic [5:0] m_key_p, m_key_a;
`endif
  logic       m_vs_prev;

  layer_compositor_m #(
    .LAYERS(3), .CBITS(2), .LATENCY(LAT), .CTRL_BASE(64), .VRAM_ADDR_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .layer_rgb(layer_rgb), .layer_valid(layer_valid),
    .visible(visible), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_en(wr_en), .address(address), .data(data),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Predict this cycle's output, clock once, and pop the entry now due.
  task automatic cycle(output logic [7:0] exp_o, output logic have_o);
    logic [2:0] mk;
    logic [5:0] bk, pix, px;
`ifdef COMPOSITOR_COLOR_KEY_EN
    logic [5:0] ky;
`endif
    logic vs_start, found;
    if (rst) begin
      sb.delete();
      for (int i = 0; i < LAT; i++) sb.push_back(8'h03);
      m_mask_p = 3'b111; m_mask_a = 3'b111;
      m_back_p = 6'h00;  m_back_a = 6'h00;
`ifdef COMPOSITOR_COLOR_KEY_EN
      m_key_p = 6'h3F;   m_key_a = 6'h3F;
`endif
      m_vs_prev = 1'b1;
    end else begin
      vs_start = !vsync_in && m_vs_prev;
      mk = vs_start ? m_mask_p : m_mask_a;
      bk = vs_start ? m_back_p : m_back_a;
`ifdef COMPOSITOR_COLOR_KEY_EN
      ky = vs_start ? m_key_p : m_key_a;
`endif
      pix = bk;
      found = 1'b0;
      for (int i = 0; i < 3; i++) begin
        px = layer_rgb[i*6 +: 6];
`ifdef COMPOSITOR_COLOR_KEY_EN
        if (!found && layer_valid[i] && mk[i] && px != ky) begin
`else
        if (!found && layer_valid[i] && mk[i]) begin
`endif
          pix = px;
          found = 1'b1;
        end
      end
      if (!visible) pix = 6'h00;
      sb.push_back({pix, hsync_in, vsync_in});
      if (vs_start) begin
        m_mask_a = m_mask_p;
        m_back_a = m_back_p;
`ifdef COMPOSITOR_COLOR_KEY_EN
        m_key_a = m_key_p;
`endif
      end
      if (wr_en) begin
        if (address == BASE) m_mask_p = data[2:0];
        if (address == BASE + 16'd1) m_back_p = data[5:0];
`ifdef COMPOSITOR_COLOR_KEY_EN
        if (address == BASE + 16'd2) m_key_p = data[5:0];
`endif
      end
      m_vs_prev = vsync_in;
    end
    @(posedge clk);
    #1;
    have_o = 1'b0;
    exp_o  = 8'h00;
    if (sb.size() == LAT) begin
      exp_o  = sb.pop_front();
      have_o = 1'b1;
    end
  endtask

  task automatic set_px(input logic [5:0] c0, input logic [5:0] c1, input logic [5:0] c2,
                        input logic [2:0] v);
    layer_rgb   = {c2, c1, c0};
    layer_valid = v;
  endtask

  task automatic test_reset();
    logic [7:0] exp, got;
    logic have;
    for (int n = 0; n < 6; n++) begin
      rst = (n < 2);
      cycle(exp, have);
      got = {r, g, b, hsync, vsync};
      if (have) begin
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL reset[%0d]: got %h expected %h", n, got, exp);
        end
      end
      if (n < 2) begin
        checks++;
        if (got !== 8'h03) begin
          errors++;
          $display("FAIL reset_value[%0d]: got %h expected 03", n, got);
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [7:0] exp, got;
    logic have;
    logic [2:0] vt [4];
    logic [5:0] et [4];
    vt = '{3'b111, 3'b110, 3'b100, 3'b000};
    et = '{6'h30, 6'h0C, 6'h03, 6'h00};
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 4; n++) begin
        set_px(6'h30, 6'h0C, 6'h03, vt[k]);
        cycle(exp, have);
        got = {r, g, b, hsync, vsync};
        if (have) begin
          checks++;
          if (got !== exp) begin
            errors++;
            $display("FAIL priority[%0d.%0d]: got %h expected %h", k, n, got, exp);
          end
        end
        if (n == 3) begin
          checks++;
          if ({r, g, b} !== et[k]) begin
            errors++;
            $display("FAIL priority_const[%0d]: got %h expected %h", k, {r, g, b}, et[k]);
          end
        end
      end
    end
  endtask

  task automatic test_backdrop();
    logic [7:0] exp, got;
    logic have;
    set_px(6'h30, 6'h0C, 6'h03, 3'b000);
    address = BASE + 16'd1;
    data    = 8'h15;
    for (int n = 0; n < 12; n++) begin
      wr_en    = (n == 0);
      vsync_in = !(n == 4 || n == 5);
      visible  = (n < 9);
      cycle(exp, have);
      got = {r, g, b, hsync, vsync};
      if (have) begin
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL backdrop[%0d]: got %h expected %h", n, got, exp);
        end
      end
      if (n == 7 || n == 11) begin
        checks++;
        if ({r, g, b} !== ((n == 7) ? 6'h15 : 6'h00)) begin
          errors++;
          $display("FAIL backdrop_const[%0d]: got %h expected %h", n, {r, g, b},
                   (n == 7) ? 6'h15 : 6'h00);
        end
      end
    end
    visible = 1'b1;
  endtask

  task automatic test_mask_sync();
    logic [7:0] exp, got;
    logic have;
    set_px(6'h30, 6'h0C, 6'h03, 3'b111);
    address = BASE;
    data    = 8'h02;
    for (int n = 0; n < 12; n++) begin
      wr_en    = (n == 2);
      vsync_in = !(n == 7 || n == 8);
      cycle(exp, have);
      got = {r, g, b, hsync, vsync};
      if (have) begin
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL mask_sync[%0d]: got %h expected %h", n, got, exp);
        end
      end
      // Output at n corresponds to input n-2: layer 0 through input 6, layer 1 from 7.
      if (n >= 4) begin
        checks++;
        if ({r, g, b} !== ((n < 9) ? 6'h30 : 6'h0C)) begin
          errors++;
          $display("FAIL mask_sync_const[%0d]: got %h expected %h", n, {r, g, b},
                   (n < 9) ? 6'h30 : 6'h0C);
        end
      end
    end
  endtask

  task automatic test_latency();
    logic [7:0] exp, got;
    logic have;
    for (int n = 0; n < 16; n++) begin
      hsync_in = n[1];
      set_px(6'((n * 5) % 64), 6'h0C, 6'h03, 3'b001);
      cycle(exp, have);
      got = {r, g, b, hsync, vsync};
      if (have) begin
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL latency[%0d]: got %h expected %h", n, got, exp);
        end
      end
    end
    hsync_in = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp, got;
    logic have;
    set_px(6'h30, 6'h0C, 6'h03, 3'b111);
    address = BASE;
    data    = 8'h04;
    for (int n = 0; n < 12; n++) begin
      rst      = (n == 3);
      wr_en    = (n == 3);
      vsync_in = !(n == 6 || n == 7);
      cycle(exp, have);
      got = {r, g, b, hsync, vsync};
      if (have) begin
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL reset_mid[%0d]: got %h expected %h", n, got, exp);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_key_and_decode();
    logic [7:0] exp, got;
    logic have;
    set_px(6'h3F, 6'h01, 6'h03, 3'b011);
    for (int n = 0; n < 20; n++) begin
      wr_en    = (n == 1 || n == 2 || n == 3 || n == 9);
      address  = (n == 2) ? BASE + 16'd3 : (n == 3) ? BASE - 16'd1 : BASE + 16'd2;
      data     = (n == 1) ? 8'h3F : (n == 9) ? 8'h01 : 8'h00;
      vsync_in = !(n == 5 || n == 13);
      cycle(exp, have);
      got = {r, g, b, hsync, vsync};
      if (have) begin
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL key[%0d]: got %h expected %h", n, got, exp);
        end
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp, got;
    logic have;
    logic [5:0] pal [4];
    pal = '{6'h3F, 6'h01, 6'h2A, 6'h15};
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      address  = BASE + 16'($urandom_range(0, 3));
      data     = 8'($urandom);
      vsync_in = ($urandom_range(0, 5) != 0);
      hsync_in = ($urandom_range(0, 3) != 0);
      visible  = ($urandom_range(0, 7) != 0);
      set_px(($urandom_range(0, 1) == 0) ? pal[$urandom_range(0, 3)] : 6'($urandom),
             pal[$urandom_range(0, 3)], 6'($urandom), 3'($urandom));
      cycle(exp, have);
      got = {r, g, b, hsync, vsync};
      if (have) begin
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got %h expected %h", n, got, exp);
        end
      end
    end
    rst = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; wr_en = 1'b0; address = '0; data = '0;
    layer_rgb = '0; layer_valid = '0;
    visible = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    m_mask_p = 3'b111; m_mask_a = 3'b111;
    m_back_p = 6'h00;  m_back_a = 6'h00;
`ifdef COMPOSITOR_COLOR_KEY_EN
    m_key_p = 6'h3F;   m_key_a = 6'h3F;
`endif
    m_vs_prev = 1'b1;
    @(negedge clk);
    test_reset();
    test_priority();
    test_backdrop();
    test_mask_sync();
    test_latency();
    test_reset_mid();
    test_key_and_decode();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
